// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble-serial datapath.
package nibble_pkg;

  localparam int NIBBLE_W     = 4;
  localparam int WORD_NIBBLES = 8;

  typedef logic [NIBBLE_W-1:0]                     nibble_t;
  typedef logic [WORD_NIBBLES-1:0][NIBBLE_W-1:0]   nibble_word_t;
  typedef logic [2:0]                              nibble_idx_t;

  // Raw state encodings, kept as plain vectors for legacy tooling.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    WS_IDLE = ST_IDLE,
    WS_SEND = ST_SEND,
    WS_DONE = ST_DONE
  } writer_state_t;

  // Pick nibble i out of a packed word.
  function automatic nibble_t nibble_sel(input nibble_word_t w, input nibble_idx_t i);
    return w[i];
  endfunction

endpackage

// File: rtl/nibble_word_writer_if.sv
// 4-bit nibble bus with valid/ready handshake.
interface nibble_word_writer_if #(
  parameter int ADDR_W = 8
);

  logic                 valid;
  logic                 ready;
  logic [ADDR_W-1:0]    addr;
  nibble_pkg::nibble_t  data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/nibble_word_writer_idx_counter.sv
// Nibble index counter: loadable, up/down, with a last-index compare.
module nibble_idx_counter
  import nibble_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  nibble_idx_t load_val,
  input  logic        load_down,
  input  nibble_idx_t load_last,
  input  logic        step,
  output nibble_idx_t idx_next,
  output logic        is_last
);

  nibble_idx_t idx_r;
  nibble_idx_t last_r;
  logic        down_r;
  nibble_idx_t idx_next_s;
  logic        is_last_s;

  // Next index: load wins over step, otherwise hold.
  always_comb begin
    idx_next_s = idx_r;
    if (load) begin
      idx_next_s = load_val;
    end else if (step) begin
      if (down_r) begin
        idx_next_s = idx_r - 3'd1;
      end else begin
        idx_next_s = idx_r + 3'd1;
      end
    end else begin
      idx_next_s = idx_r;
    end
  end

  // Terminal index is 0 when counting down, the latched last index when counting up.
  always_comb begin
    is_last_s = 1'b0;
    if (down_r) begin
      is_last_s = (idx_r == 3'd0);
    end else begin
      is_last_s = (idx_r == last_r);
    end
  end

  // Index, direction and last-index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r  <= 3'd0;
      last_r <= 3'd0;
      down_r <= 1'b0;
    end else begin
      idx_r <= idx_next_s;
      if (load) begin
        last_r <= load_last;
        down_r <= load_down;
      end else begin
        last_r <= last_r;
        down_r <= down_r;
      end
    end
  end

  assign idx_next = idx_next_s;
  assign is_last  = is_last_s;

endmodule

// File: rtl/nibble_word_writer.sv
// Streams a latched 32-bit word onto a 4-bit bus, LSB- or MSB-first.
module nibble_word_writer
  import nibble_pkg::*;
#(
  parameter int ADDR_W = 8
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [31:0]                  word,
  input  nibble_idx_t                  nibbles_number,
  input  logic                         msb_first,
  input  logic [ADDR_W-1:0]            base_addr,
  nibble_word_writer_if.master         bus,
  output logic                         busy,
  output logic                         done
);

  writer_state_t     state_r;
  writer_state_t     state_nxt_s;
  nibble_word_t      word_r;
  logic [ADDR_W-1:0] base_r;
  logic              valid_r;
  logic              busy_r;
  logic              done_r;
  nibble_t           data_r;
  logic [ADDR_W-1:0] addr_r;

  logic              start_acc_s;
  logic              xfer_s;
  logic              step_s;
  logic              last_s;
  nibble_idx_t       load_val_s;
  nibble_idx_t       idx_next_s;
  nibble_word_t      src_word_s;
  logic [ADDR_W-1:0] src_base_s;

  assign start_acc_s = (state_r == WS_IDLE) && start;
  assign xfer_s      = (state_r == WS_SEND) && valid_r && bus.ready;
  assign step_s      = xfer_s && !last_s;

  // Starting index depends on write direction.
  always_comb begin
    load_val_s = 3'd0;
    if (msb_first) begin
      load_val_s = nibbles_number;
    end else begin
      load_val_s = 3'd0;
    end
  end

  nibble_idx_counter u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_acc_s),
    .load_val  (load_val_s),
    .load_down (msb_first),
    .load_last (nibbles_number),
    .step      (step_s),
    .idx_next  (idx_next_s),
    .is_last   (last_s)
  );

  // On the accepting edge the bus registers are loaded straight from the request.
  always_comb begin
    src_word_s = word_r;
    src_base_s = base_r;
    if (start_acc_s) begin
      src_word_s = word;
      src_base_s = base_addr;
    end else begin
      src_word_s = word_r;
      src_base_s = base_r;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WS_IDLE: begin
        if (start) begin
          state_nxt_s = WS_SEND;
        end else begin
          state_nxt_s = WS_IDLE;
        end
      end
      WS_SEND: begin
        if (xfer_s && last_s) begin
          state_nxt_s = WS_DONE;
        end else begin
          state_nxt_s = WS_SEND;
        end
      end
      WS_DONE: state_nxt_s = WS_IDLE;
      default: state_nxt_s = WS_IDLE;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WS_IDLE;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s == WS_SEND);
      busy_r  <= (state_nxt_s == WS_SEND);
      done_r  <= (state_nxt_s == WS_DONE);
    end
  end

  // Latched request and the bus data/address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= '0;
      base_r <= '0;
      data_r <= 4'd0;
      addr_r <= '0;
    end else begin
      if (start_acc_s) begin
        word_r <= word;
        base_r <= base_addr;
      end else begin
        word_r <= word_r;
        base_r <= base_r;
      end
      if (start_acc_s || step_s) begin
        data_r <= nibble_sel(src_word_s, idx_next_s);
        addr_r <= src_base_s + ADDR_W'(idx_next_s);
      end else begin
        data_r <= data_r;
        addr_r <= addr_r;
      end
    end
  end

  assign bus.valid = valid_r;
  assign bus.data  = data_r;
  assign bus.addr  = addr_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
